// File: rtl/tc_deser_if.sv
// tc_deser_if
// Bundles the serial input side and the parallel word handshake of the
// two's complement deserializer.
//
// Parameter:
//   N           word width in bits (2..32)
// Signals:
//   b_in        serial data bit, LSB of the word first
//   b_valid     qualifies b_in for the current cycle
//   clr         synchronous frame restart
//   word        assembled word, stable while word_valid=1
//   word_valid  output buffer holds an unconsumed word
//   word_ready  consumer accepts word when word_valid=1
//   overrun     sticky flag: a completed word was dropped
//   ovf         only with TC_OVF_FLAG_EN: held word is 1 followed by N-1 zeros
// Modports:
//   master      the deserializer (drives word/word_valid/overrun[/ovf])
//   slave       the environment (drives serial bits, clr and word_ready)
// Optional feature macro: TC_OVF_FLAG_EN
interface tc_deser_if #(
    parameter int N = 8
);
    logic         b_in;
    logic         b_valid;
    logic         clr;
    logic [N-1:0] word;
    logic         word_valid;
    logic         word_ready;
    logic         overrun;
`ifdef TC_OVF_FLAG_EN
    logic         ovf;

    modport master (
        input  b_in, b_valid, clr, word_ready,
        output word, word_valid, overrun, ovf
    );

    modport slave (
        output b_in, b_valid, clr, word_ready,
        input  word, word_valid, overrun, ovf
    );
`else
    modport master (
        input  b_in, b_valid, clr, word_ready,
        output word, word_valid, overrun
    );

    modport slave (
        output b_in, b_valid, clr, word_ready,
        input  word, word_valid, overrun
    );
`endif
endinterface

// File: rtl/tc_deser.sv
// tc_deser
// Serial-to-parallel collector for the bit-serial two's complement
// generator. Assembles N-bit words (LSB first) and presents each completed
// word through a single-entry output buffer with a valid/ready handshake.
// Words completing while the buffer is full and not being drained are
// dropped and recorded in a sticky overrun flag.
//
// Parameter:
//   N       word width in bits (2..32)
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus     tc_deser_if.master (serial input, word handshake, overrun[, ovf])
// Optional feature macro: TC_OVF_FLAG_EN
//   When defined, an ovf flag is loaded alongside each word; it is 1 when
//   the word equals 1 followed by N-1 zeros (the negation that overflows).
module tc_deser #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    tc_deser_if.master    bus
);

    localparam int CW = $clog2(N);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  word_q, word_d;
    logic [0:0]    state_q, state_d;
    logic          overrun_q, overrun_d;

    logic          complete;
    logic [N-1:0]  completed;

    // A bit arriving together with clr is discarded, so it can never
    // complete a word.
    assign completed = {bus.b_in, sreg_q[N-1:1]};
    assign complete  = bus.b_valid && !bus.clr && (cnt_q == CW'(N - 1));

    // Shift register and bit counter; clr restarts the frame.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (bus.clr) begin
            sreg_d = '0;
            cnt_d  = '0;
        end else if (bus.b_valid) begin
            sreg_d = completed;
            cnt_d  = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    // Single-entry output buffer. A drain and a new completion on the same
    // edge replace the word without a bubble, which keeps back-to-back
    // words at full rate.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    word_d  = completed;
                    state_d = ST_FULL;
                end
            end
            default: begin
                if (bus.word_ready) begin
                    if (complete) begin
                        word_d = completed;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (complete) begin
                    overrun_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q    <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            state_q   <= ST_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = (state_q == ST_FULL);
    assign bus.overrun    = overrun_q;

`ifdef TC_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // The flag follows the word buffer exactly: it changes only when a new
    // word is loaded.
    always_comb begin
        ovf_d = ovf_q;
        if (complete && ((state_q == ST_EMPTY) || bus.word_ready)) begin
            ovf_d = (completed == {1'b1, {(N - 1){1'b0}}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
